// File: rtl/ds_ctrl_pkg.sv
// Shared definitions for the data-stack spill/fill sequencer: state encoding
// and the default base address of the spill area in data memory.
package ds_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SPILL = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] EXEC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SPILL = SPILL,
    ST_FILL  = FILL,
    ST_EXEC  = EXEC
  } ds_state_t;

  localparam logic [15:0] SPILL_BASE_DEFAULT = 16'hF000;

endpackage

// File: rtl/ds_spill_ctrl_if.sv
// Command handshake (control unit -> sequencer) and data-memory request bus
// (sequencer -> memory) used by ds_spill_ctrl.
interface ds_cmd_if;
  logic op_push;
  logic op_pop;
  logic op_ready;

  modport master (output op_push, op_pop, input op_ready);
  modport slave  (input op_push, op_pop, output op_ready);
endinterface

interface ds_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/ds_occupancy.sv
// Occupancy tracking for the register stack and its memory overflow area,
// with the decodes the sequencer needs to choose between spill, fill and plain ops.
module ds_occupancy
  import ds_ctrl_pkg::*;
#(
  parameter int DEPTH     = 128,
  parameter int MEM_DEPTH = 4096,
  parameter int ADDR_W    = 16,
  localparam int REG_CW   = $clog2(DEPTH + 1),
  localparam int MEM_CW   = $clog2(MEM_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              async_reset_n,
  input  logic              inc_reg,
  input  logic              dec_reg,
  input  logic              inc_mem,
  input  logic              dec_mem,
  output logic [MEM_CW-1:0] mem_count,
  output logic              reg_empty,
  output logic              mem_empty,
  output logic              mem_full,
  output logic              spill_needed,
  output logic              fill_needed,
  output logic [ADDR_W-1:0] total_size
);

  localparam logic [REG_CW-1:0] REG_FULL_V = REG_CW'(DEPTH);
  localparam logic [MEM_CW-1:0] MEM_FULL_V = MEM_CW'(MEM_DEPTH);

  logic [REG_CW-1:0] reg_count_reg, reg_count_next;
  logic [MEM_CW-1:0] mem_count_reg, mem_count_next;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      reg_count_reg <= '0;
      mem_count_reg <= '0;
    end else begin
      reg_count_reg <= reg_count_next;
      mem_count_reg <= mem_count_next;
    end
  end

  always_comb begin
    reg_count_next = reg_count_reg;
    mem_count_next = mem_count_reg;
    if (inc_reg) begin
      reg_count_next = reg_count_reg + REG_CW'(1);
    end else if (dec_reg) begin
      reg_count_next = reg_count_reg - REG_CW'(1);
    end
    if (inc_mem) begin
      mem_count_next = mem_count_reg + MEM_CW'(1);
    end else if (dec_mem) begin
      mem_count_next = mem_count_reg - MEM_CW'(1);
    end
  end

  assign mem_count    = mem_count_reg;
  assign reg_empty    = (reg_count_reg == '0);
  assign mem_empty    = (mem_count_reg == '0);
  assign mem_full     = (mem_count_reg == MEM_FULL_V);
  assign spill_needed = (reg_count_reg == REG_FULL_V);
  // Entries only live in memory while the register stack is full, so any
  // memory occupancy means the next pop must refill sr127 first.
  assign fill_needed  = !mem_empty;
  assign total_size   = ADDR_W'(reg_count_reg) + ADDR_W'(mem_count_reg);

endmodule

// File: rtl/ds_spill_ctrl.sv
// Push/pop sequencer for the register data stack: spills the bottom entry to
// memory before a push into a full stack and refills it before a pop.
module ds_spill_ctrl
  import ds_ctrl_pkg::*;
#(
  parameter int                DEPTH      = 128,
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] SPILL_BASE = SPILL_BASE_DEFAULT,
  parameter int                MEM_DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              async_reset_n,
  ds_cmd_if.slave           cmd,
  ds_mem_if.master          mem,
  output logic              ds_push,
  output logic              ds_data_write,
  output logic              ds_pop,
  output logic              ds_data_read,
  input  logic [DATA_W-1:0] sr127_out,
  output logic [DATA_W-1:0] sr127_in,
  output logic [ADDR_W-1:0] total_size,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic              err_conflict
);

  localparam int MEM_CW = $clog2(MEM_DEPTH + 1);

  ds_state_t state_reg, state_next;

  logic              exec_push_reg, exec_push_next;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] fill_reg;
  logic              err_overflow_reg, err_underflow_reg, err_conflict_reg;

  logic inc_reg, dec_reg, inc_mem, dec_mem;
  logic load_spill, load_fill, capture_fill, clear_fill;
  logic set_overflow, set_underflow, set_conflict, clear_err;

  logic [MEM_CW-1:0] mem_count;
  logic              reg_empty, mem_empty, mem_full, spill_needed, fill_needed;
  logic [ADDR_W-1:0] spill_addr, fill_addr;
  logic              is_idle, want_push, want_pop, both_ops;

  ds_occupancy #(
    .DEPTH     (DEPTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_occupancy (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .inc_reg       (inc_reg),
    .dec_reg       (dec_reg),
    .inc_mem       (inc_mem),
    .dec_mem       (dec_mem),
    .mem_count     (mem_count),
    .reg_empty     (reg_empty),
    .mem_empty     (mem_empty),
    .mem_full      (mem_full),
    .spill_needed  (spill_needed),
    .fill_needed   (fill_needed),
    .total_size    (total_size)
  );

  // Next free slot for a spill; the most recently spilled slot for a fill.
  assign spill_addr = SPILL_BASE + ADDR_W'(mem_count);
  assign fill_addr  = SPILL_BASE + ADDR_W'(mem_count) - ADDR_W'(1);

  assign is_idle   = (state_reg == ST_IDLE);
  assign want_push = is_idle && cmd.op_push && !cmd.op_pop;
  assign want_pop  = is_idle && cmd.op_pop && !cmd.op_push;
  assign both_ops  = is_idle && cmd.op_push && cmd.op_pop;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    exec_push_next = exec_push_reg;
    inc_reg        = 1'b0;
    dec_reg        = 1'b0;
    inc_mem        = 1'b0;
    dec_mem        = 1'b0;
    load_spill     = 1'b0;
    load_fill      = 1'b0;
    capture_fill   = 1'b0;
    clear_fill     = 1'b0;
    set_overflow   = 1'b0;
    set_underflow  = 1'b0;
    set_conflict   = 1'b0;
    clear_err      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (both_ops) begin
          set_conflict = 1'b1;
        end else if (want_push) begin
          if (!spill_needed) begin
            state_next     = ST_EXEC;
            exec_push_next = 1'b1;
            inc_reg        = 1'b1;
            clear_err      = 1'b1;
          end else if (!mem_full) begin
            state_next     = ST_SPILL;
            exec_push_next = 1'b1;
            load_spill     = 1'b1;
            clear_err      = 1'b1;
          end else begin
            set_overflow = 1'b1;
          end
        end else if (want_pop) begin
          if (fill_needed) begin
            state_next     = ST_FILL;
            exec_push_next = 1'b0;
            load_fill      = 1'b1;
            clear_err      = 1'b1;
          end else if (!reg_empty) begin
            state_next     = ST_EXEC;
            exec_push_next = 1'b0;
            dec_reg        = 1'b1;
            clear_fill     = 1'b1;
            clear_err      = 1'b1;
          end else if (mem_empty) begin
            set_underflow = 1'b1;
          end
        end
      end
      ST_SPILL: begin
        if (mem.mem_ack) begin
          inc_mem    = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_FILL: begin
        if (mem.mem_ack) begin
          dec_mem      = 1'b1;
          capture_fill = 1'b1;
          state_next   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request fields are captured at acceptance so they stay stable until ack.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      exec_push_reg <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      fill_reg      <= '0;
    end else begin
      exec_push_reg <= exec_push_next;
      if (load_spill) begin
        mem_we_reg    <= 1'b1;
        mem_addr_reg  <= spill_addr;
        mem_wdata_reg <= sr127_out;
      end else if (load_fill) begin
        mem_we_reg   <= 1'b0;
        mem_addr_reg <= fill_addr;
      end
      if (capture_fill) begin
        fill_reg <= mem.mem_rdata;
      end else if (clear_fill) begin
        fill_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
      err_conflict_reg  <= 1'b0;
    end else if (clear_err) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
      err_conflict_reg  <= 1'b0;
    end else begin
      err_overflow_reg  <= err_overflow_reg  | set_overflow;
      err_underflow_reg <= err_underflow_reg | set_underflow;
      err_conflict_reg  <= err_conflict_reg  | set_conflict;
    end
  end

  assign cmd.op_ready  = is_idle;
  assign mem.mem_req   = (state_reg == ST_SPILL) || (state_reg == ST_FILL);
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;

  assign ds_push       = (state_reg == ST_EXEC) && exec_push_reg;
  assign ds_data_write = ds_push;
  assign ds_pop        = (state_reg == ST_EXEC) && !exec_push_reg;
  assign ds_data_read  = ds_pop;
  assign sr127_in      = fill_reg;

  assign err_overflow  = err_overflow_reg;
  assign err_underflow = err_underflow_reg;
  assign err_conflict  = err_conflict_reg;

endmodule

// File: tb/tb_ds_spill_ctrl.sv
// Directed scoreboard bench for ds_spill_ctrl with a two-entry spill area so
// spill, fill, overflow and reset-during-spill are all reachable quickly.
module tb_ds_spill_ctrl;

  localparam int DEPTH = 128;
  localparam int MEMD  = 2;

  typedef struct {
    logic        is_push;
    logic [15:0] size;
    logic [15:0] fill;
  } exec_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } memx_t;

  logic        clk = 1'b0;
  logic        async_reset_n = 1'b0;
  logic        ds_push, ds_data_write, ds_pop, ds_data_read;
  logic [15:0] sr127_out, sr127_in, total_size;
  logic        err_overflow, err_underflow, err_conflict;

  ds_cmd_if cmd_bus ();
  ds_mem_if #(.DATA_W(16), .ADDR_W(16)) mem_bus ();

  ds_spill_ctrl #(
    .DEPTH      (DEPTH),
    .DATA_W     (16),
    .ADDR_W     (16),
    .SPILL_BASE (16'hF000),
    .MEM_DEPTH  (MEMD)
  ) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .cmd           (cmd_bus.slave),
    .mem           (mem_bus.master),
    .ds_push       (ds_push),
    .ds_data_write (ds_data_write),
    .ds_pop        (ds_pop),
    .ds_data_read  (ds_data_read),
    .sr127_out     (sr127_out),
    .sr127_in      (sr127_in),
    .total_size    (total_size),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_conflict  (err_conflict)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    op_id  = 0;
  int    m_reg  = 0;
  int    m_mem  = 0;
  logic  e_ovf  = 1'b0;
  logic  e_unf  = 1'b0;
  logic  e_conf = 1'b0;
  exec_t exec_q[$];
  memx_t mem_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s op%0d: observed %0h expected %0h", tag, op_id, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags();
    chk("err_overflow", err_overflow, e_ovf);
    chk("err_underflow", err_underflow, e_unf);
    chk("err_conflict", err_conflict, e_conf);
  endtask

  // One command end to end: model predicts, scoreboard holds the expectation,
  // the DUT response is popped and compared as it appears.
  task automatic run_op(input logic p, input logic q, input int dly, input logic [15:0] rd);
    exec_t ex, got_ex;
    memx_t mx, got_mx;
    bit    do_mem = 0;
    bit    do_exec = 0;
    op_id++;
    sr127_out = 16'hA000 ^ 16'(op_id);
    mx = '{1'b0, 16'h0, 16'h0};
    if (p && q) begin
      e_conf = 1'b1;
    end else if (p) begin
      if (m_reg < DEPTH) begin
        do_exec = 1; m_reg++;
      end else if (m_mem < MEMD) begin
        do_exec = 1; do_mem = 1;
        mx = '{1'b1, 16'hF000 + 16'(m_mem), sr127_out};
        m_mem++;
      end else begin
        e_ovf = 1'b1;
      end
    end else if (q) begin
      if (m_mem > 0) begin
        do_exec = 1; do_mem = 1; m_mem--;
        mx = '{1'b0, 16'hF000 + 16'(m_mem), 16'h0};
      end else if (m_reg > 0) begin
        do_exec = 1; m_reg--;
      end else begin
        e_unf = 1'b1;
      end
    end
    if (do_exec) begin
      e_ovf = 1'b0; e_unf = 1'b0; e_conf = 1'b0;
      ex = '{p, 16'(m_reg + m_mem), (do_mem ? rd : 16'h0)};
      exec_q.push_back(ex);
    end
    if (do_mem) mem_q.push_back(mx);

    chk("ready_idle", cmd_bus.op_ready, 1);
    cmd_bus.op_push = p;
    cmd_bus.op_pop  = q;
    tick();
    cmd_bus.op_push = 1'b0;
    cmd_bus.op_pop  = 1'b0;

    if (do_mem) begin
      got_mx = mem_q.pop_front();
      chk("mem_req", mem_bus.mem_req, 1);
      chk("mem_we", mem_bus.mem_we, got_mx.we);
      chk("mem_addr", mem_bus.mem_addr, got_mx.addr);
      if (got_mx.we) chk("mem_wdata", mem_bus.mem_wdata, got_mx.wdata);
      for (int i = 0; i < dly; i++) begin
        tick();
        chk("mem_req_hold", mem_bus.mem_req, 1);
        chk("mem_addr_hold", mem_bus.mem_addr, got_mx.addr);
        chk("mem_we_hold", mem_bus.mem_we, got_mx.we);
      end
      mem_bus.mem_rdata = rd;
      mem_bus.mem_ack   = 1'b1;
      tick();
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 16'h0;
    end

    if (do_exec) begin
      got_ex = exec_q.pop_front();
      chk("ds_push", ds_push, got_ex.is_push);
      chk("ds_data_write", ds_data_write, got_ex.is_push);
      chk("ds_pop", ds_pop, !got_ex.is_push);
      chk("ds_data_read", ds_data_read, !got_ex.is_push);
      chk("total_size", total_size, got_ex.size);
      if (!got_ex.is_push) chk("sr127_in", sr127_in, got_ex.fill);
      chk("mem_req_exec", mem_bus.mem_req, 0);
      chk("ready_exec", cmd_bus.op_ready, 0);
    end else begin
      chk("no_strobes", {ds_push, ds_data_write, ds_pop, ds_data_read}, 0);
      chk("no_mem_req", mem_bus.mem_req, 0);
      chk("size_kept", total_size, m_reg + m_mem);
      chk("ready_err", cmd_bus.op_ready, 1);
    end
    chk_flags();
    tick();
    chk("strobes_off", {ds_push, ds_data_write, ds_pop, ds_data_read}, 0);
    chk("ready_back", cmd_bus.op_ready, 1);
  endtask

  initial begin
    cmd_bus.op_push   = 1'b0;
    cmd_bus.op_pop    = 1'b0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 16'h0;
    sr127_out         = 16'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {ds_push, ds_data_write, ds_pop, ds_data_read}, 0);
    chk("rst_mem", {mem_bus.mem_req, mem_bus.mem_we}, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_wdata", mem_bus.mem_wdata, 0);
    chk("rst_sr127_in", sr127_in, 0);
    chk("rst_ready", cmd_bus.op_ready, 1);
    chk("rst_size", total_size, 0);
    chk_flags();
    @(negedge clk);
    async_reset_n = 1'b1;
    tick();

    // Plain register-stack traffic: sizes 1,2,3,2,1,0.
    for (int i = 0; i < 3; i++) run_op(1'b1, 1'b0, 0, 16'h0);
    for (int i = 0; i < 3; i++) run_op(1'b0, 1'b1, 0, 16'h0);

    // Underflow, recovery, conflict, recovery.
    run_op(1'b0, 1'b1, 0, 16'h0);
    run_op(1'b1, 1'b0, 0, 16'h0);
    run_op(1'b1, 1'b1, 0, 16'h0);
    run_op(1'b0, 1'b1, 0, 16'h0);

    // Fill the register stack, then spill twice.
    for (int i = 0; i < DEPTH; i++) run_op(1'b1, 1'b0, 0, 16'h0);
    run_op(1'b1, 1'b0, 3, 16'h0);
    run_op(1'b1, 1'b0, 1, 16'h0);

    // Refill from the top spilled slot, re-spill, then overflow.
    run_op(1'b0, 1'b1, 2, 16'hBEEF);
    run_op(1'b1, 1'b0, 0, 16'h0);
    run_op(1'b1, 1'b0, 0, 16'h0);

    // Drain memory back, then a plain pop that must present zero fill data.
    run_op(1'b0, 1'b1, 0, 16'h1234);
    run_op(1'b0, 1'b1, 4, 16'h5678);
    run_op(1'b0, 1'b1, 0, 16'h0);
    run_op(1'b1, 1'b0, 0, 16'h0);

    // Reset while a spill is waiting for its ack.
    op_id++;
    chk("pre_spill_size", total_size, DEPTH);
    cmd_bus.op_push = 1'b1;
    tick();
    cmd_bus.op_push = 1'b0;
    chk("spill_started", mem_bus.mem_req, 1);
    tick();
    #2 async_reset_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", mem_bus.mem_req, 0);
    chk("rst_mid_size", total_size, 0);
    chk("rst_mid_ready", cmd_bus.op_ready, 1);
    chk("rst_mid_strobes", {ds_push, ds_pop}, 0);
    chk("rst_mid_addr", mem_bus.mem_addr, 0);
    m_reg = 0; m_mem = 0;
    e_ovf = 1'b0; e_unf = 1'b0; e_conf = 1'b0;
    exec_q.delete();
    mem_q.delete();
    @(negedge clk);
    async_reset_n = 1'b1;
    tick();
    run_op(1'b1, 1'b0, 0, 16'h0);

    chk("sb_exec_empty", exec_q.size(), 0);
    chk("sb_mem_empty", mem_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ds_spill_ctrl.md
# ds_spill_ctrl

Sequencer between the control unit and the 128-entry register data stack. It accepts push/pop commands through a ready/valid handshake and drives the stack's push/pop and read/write strobes. When the register stack is full, it spills the bottom entry (sr127) to data memory before a push. When entries sit in memory, it refills sr127 from memory before a pop. This gives the control unit a stack deeper than the register file, with exact size tracking and overflow/underflow flags.

## Interface
Parameters:
- DEPTH, 128, register-stack entries (must match the data stack)
- DATA_W, 16, entry width
- ADDR_W, 16, memory address width
- SPILL_BASE, 16'hF000, memory word address of the first spilled entry
- MEM_DEPTH, 4096, maximum spilled entries

Ports:
- clk  in  1  system clock, all logic on rising edge
- async_reset_n  in  1  asynchronous, active-low reset
- op_push  in  1  control requests push (data already on sr0_in of the stack)
- op_pop  in  1  control requests pop
- op_ready  out  1  command accepted on any edge where ready and exactly one of op_push/op_pop is high
- ds_push, ds_data_write  out  1  stack push strobes, always asserted together
- ds_pop, ds_data_read  out  1  stack pop strobes, always asserted together
- sr127_out  in  DATA_W  bottom register of the stack
- sr127_in  out  DATA_W  fill data shifted into sr127 on pop
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = spill write, 0 = fill read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  spill data
- mem_rdata  in  DATA_W  fill data, valid with mem_ack
- mem_ack  in  1  one-cycle completion
- total_size  out  ADDR_W  reg_count + mem_count
- err_overflow, err_underflow, err_conflict  out  1  error flags

## Operation
- Counters: reg_count (0..DEPTH, 8 bits) and mem_count (0..MEM_DEPTH).
- States: IDLE, SPILL, FILL, EXEC. op_ready is 1 only in IDLE.
- Push accepted, reg_count < DEPTH: go to EXEC; reg_count+1.
- Push accepted, reg_count == DEPTH, mem_count < MEM_DEPTH:
  - Go to SPILL: mem_we=1, mem_addr=SPILL_BASE+mem_count, mem_wdata=sr127_out captured at acceptance.
  - On mem_ack: mem_count+1, go to EXEC. reg_count stays unchanged.
- Push accepted, reg_count == DEPTH, mem_count == MEM_DEPTH: set err_overflow, stay in IDLE, no strobes.
- Pop accepted, mem_count > 0 (reg_count is then DEPTH):
  - Go to FILL: mem_we=0, mem_addr=SPILL_BASE+mem_count-1.
  - On mem_ack: latch mem_rdata into fill register (drives sr127_in), mem_count-1, go to EXEC.
- Pop accepted, mem_count == 0, reg_count > 0: go to EXEC, reg_count-1. sr127_in = 0.
- Pop accepted, total_size == 0: set err_underflow, no strobes.
- op_push and op_pop both high in IDLE: command dropped, err_conflict set.
- EXEC: the matching strobe pair is high for exactly one cycle, then return to IDLE.
- Error flags are sticky. They clear on the next accepted command that executes successfully.
- mem_ack outside SPILL/FILL is ignored.

## Timing
- Reset values: all strobes 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, sr127_in 0, op_ready 1, total_size 0, all error flags 0.
- Reset asserted mid-transaction: state returns to IDLE and mem_req drops immediately. The memory access is abandoned and the counters clear.
- Non-memory op: accepted at edge N; strobes high during cycle N+1; op_ready back high at N+2. Throughput is 1 op per 2 cycles.
- Memory op: mem_req rises at cycle N+1 and holds stable (addr/we/wdata) until the mem_ack edge. EXEC follows the next cycle. Latency is 2 + memory wait cycles.
- sr127_in is stable from the cycle after mem_ack through the EXEC cycle.
- total_size updates on the same edge as the counter change, so it reflects the committed state before the strobes.

## Structure
- Shared package ds_ctrl_pkg holds the state encoding localparams (IDLE=2'd0, SPILL=2'd1, FILL=2'd2, EXEC=2'd3) and the SPILL_BASE default.
- Sub-module ds_occupancy holds reg_count/mem_count, the full/empty/spill-needed/fill-needed decodes and total_size. The FSM is in the top level.

## Test plan
- Reset, then 3 pushes and 3 pops: total_size goes 1, 2, 3, 2, 1, 0; each op produces a one-cycle strobe pair 1 cycle after acceptance; no mem_req.
- 129 pushes: on push 129, mem_req with mem_we=1, addr=16'hF000, wdata=sr127_out value; ack after 3 cycles gives ds_push one cycle later and total_size=129.
- From total_size=130, pop: FILL read at 16'hF001; mem_rdata=16'hBEEF is presented on sr127_in during the ds_pop cycle; total_size=129.
- Pop at size 0 gives err_underflow=1 and no strobes; a following push clears it and total_size=1.
- op_push and op_pop together gives err_conflict=1 and counters unchanged; with MEM_DEPTH=2 and full storage, a push gives err_overflow=1.
- async_reset_n low while SPILL is waiting for ack: mem_req drops in the same cycle, total_size=0, op_ready=1.
